// File: rtl/clock_pkg.sv
// Shared types and time constants for the digital clock time-of-day controller.
package clock_pkg;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        SET_HR  = 2'd1,
        SET_MIN = 2'd2
    } state_e;

    localparam int SECS_PER_HOUR = 3600;
    localparam int SECS_PER_MIN  = 60;
    localparam int SECS_PER_DAY  = 86400;
    localparam int HOURS_PER_DAY = 24;
    localparam int MIN_PER_HOUR  = 60;

endpackage

// File: rtl/tick_prescaler.sv
// Free-running divider producing a one-cycle seconds tick and a 50% blink phase.
module tick_prescaler #(
    parameter int CLK_HZ = 50_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic sec_tick,
    output logic blink_phase
);

    localparam int PW = (CLK_HZ > 2) ? $clog2(CLK_HZ) : 1;
    localparam logic [PW-1:0] LAST = PW'(CLK_HZ - 1);
    localparam logic [PW-1:0] HALF = PW'(CLK_HZ / 2);

    logic [PW-1:0] pc_q, pc_d;

    always_comb begin
        pc_d = pc_q + PW'(1);
        if (clear || pc_q == LAST) begin
            pc_d = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q <= '0;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign sec_tick    = (pc_q == LAST);
    assign blink_phase = (pc_q >= HALF);

endmodule

// File: rtl/clock_time_controller.sv
// Time-of-day keeper with a button-driven set-time FSM and blinking field blank mask.
module clock_time_controller
    import clock_pkg::*;
#(
    parameter int CLK_HZ = 50_000_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mode_btn,
    input  logic        inc_btn,
    output logic [31:0] seconds,
    output logic [5:0]  blank,
    output logic [1:0]  mode
);

    localparam logic [31:0] K_HOUR  = 32'(SECS_PER_HOUR);
    localparam logic [31:0] K_MIN   = 32'(SECS_PER_MIN);
    localparam logic [4:0]  HH_LAST = 5'(HOURS_PER_DAY - 1);
    localparam logic [5:0]  MM_LAST = 6'(MIN_PER_HOUR - 1);
    localparam logic [5:0]  SS_LAST = 6'(SECS_PER_MIN - 1);

    logic [1:0] state_q, state_d;
    logic [4:0] hh_q, hh_d, hh_inc;
    logic [5:0] mm_q, mm_d, mm_inc;
    logic [5:0] ss_q, ss_d;
    logic       sec_tick, blink_phase, pc_clear;

    tick_prescaler #(.CLK_HZ(CLK_HZ)) u_prescaler (
        .clk         (clk),
        .reset       (reset),
        .clear       (pc_clear),
        .sec_tick    (sec_tick),
        .blink_phase (blink_phase)
    );

    assign hh_inc = (hh_q == HH_LAST) ? 5'd0 : hh_q + 5'd1;
    assign mm_inc = (mm_q == MM_LAST) ? 6'd0 : mm_q + 6'd1;

    // A mode press always wins over an increment; in RUN it coexists with the tick.
    always_comb begin
        state_d  = state_q;
        hh_d     = hh_q;
        mm_d     = mm_q;
        ss_d     = ss_q;
        pc_clear = 1'b0;
        case (state_q)
            SET_HR: begin
                if (mode_btn)     state_d = SET_MIN;
                else if (inc_btn) hh_d = hh_inc;
            end
            SET_MIN: begin
                if (mode_btn) begin
                    state_d  = RUN;
                    ss_d     = 6'd0;
                    pc_clear = 1'b1;
                end else if (inc_btn) begin
                    mm_d = mm_inc;
                end
            end
            default: begin
                if (mode_btn) state_d = SET_HR;
                if (sec_tick) begin
                    if (ss_q == SS_LAST) begin
                        ss_d = 6'd0;
                        mm_d = mm_inc;
                        if (mm_q == MM_LAST) hh_d = hh_inc;
                    end else begin
                        ss_d = ss_q + 6'd1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= RUN;
            hh_q    <= '0;
            mm_q    <= '0;
            ss_q    <= '0;
        end else begin
            state_q <= state_d;
            hh_q    <= hh_d;
            mm_q    <= mm_d;
            ss_q    <= ss_d;
        end
    end

    assign seconds = ({27'd0, hh_q} * K_HOUR) + ({26'd0, mm_q} * K_MIN) + {26'd0, ss_q};
    assign mode    = state_q;

    always_comb begin
        blank = 6'b000000;
        if (blink_phase) begin
            if (state_q == SET_HR)  blank = 6'b110000;
            if (state_q == SET_MIN) blank = 6'b001100;
        end
    end

endmodule
